// File: rtl/instruction_memory_pkg.sv
// Shared definitions for the instruction memory and the instruction cache that talks to it.
// Block/word geometry and the responder FSM encoding.
package instruction_memory_pkg;

   localparam int BLOCK_WORDS      = 4;
   localparam int WORD_WIDTH       = 32;
   localparam int BLOCK_WIDTH      = BLOCK_WORDS * WORD_WIDTH;
   localparam int BLOCK_ADDR_WIDTH = 28;
   localparam int BEAT_WIDTH       = $clog2(BLOCK_WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FETCH = 2'd2,
      DONE  = 2'd3
   } mem_state_t;

endpackage

// File: rtl/instruction_memory_if.sv
// Cache-to-memory block read bus plus the word-wide program-load port.
// The cache (or loader) is the master; the memory is the slave.
interface instruction_memory_if;
   import instruction_memory_pkg::*;

   logic                        READ;
   logic [BLOCK_ADDR_WIDTH-1:0] ADDRESS;
   logic [BLOCK_WIDTH-1:0]      READDATA;
   logic                        BUSYWAIT;
   logic                        PROG_WRITE;
   logic [31:0]                 PROG_ADDR;
   logic [WORD_WIDTH-1:0]       PROG_DATA;

   modport master (
      output READ, ADDRESS, PROG_WRITE, PROG_ADDR, PROG_DATA,
      input  READDATA, BUSYWAIT
   );

   modport slave (
      input  READ, ADDRESS, PROG_WRITE, PROG_ADDR, PROG_DATA,
      output READDATA, BUSYWAIT
   );

endinterface

// File: rtl/instruction_memory_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, asynchronous read, no reset (contents survive RESET).
module instruction_memory_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_WIDTH  = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [31:0]           wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [31:0]           rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_memory.sv
// Block read responder: LATENCY wait cycles, then 4 word beats assembled into READDATA; BUSYWAIT low in DONE.
// Dropping READ mid-request aborts to IDLE; program writes land only when idle with no request.
module instruction_memory
   import instruction_memory_pkg::*;
#(
   parameter int LATENCY     = 4,
   parameter int DEPTH_WORDS = 1024
) (
   input logic                 CLK,
   input logic                 RESET,
   instruction_memory_if.slave bus
);

   localparam int AW  = $clog2(DEPTH_WORDS);
   localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [WCW-1:0] WAIT_INIT = (LATENCY > 0) ? WCW'(LATENCY - 1) : '0;

   mem_state_t                  state, state_nxt;
   logic [BEAT_WIDTH-1:0]       beat, beat_nxt;
   logic [WCW-1:0]              wait_cnt, wait_nxt;
   logic [BLOCK_ADDR_WIDTH-1:0] blk, blk_nxt;
   logic [BLOCK_WIDTH-1:0]      readdata;
   logic [BLOCK_ADDR_WIDTH+BEAT_WIDTH-1:0] word_full;
   logic [WORD_WIDTH-1:0]       rd_word;
   logic                        prog_en;
   logic                        load_beat;

   // Out-of-range block addresses wrap: only the low AW bits of {blk, beat} index the array.
   assign word_full = {blk, beat};
   assign prog_en   = (state == IDLE) && !bus.READ && bus.PROG_WRITE;
   assign load_beat = (state == FETCH) && bus.READ;

   logic unused;
   assign unused = &{1'b0, bus.PROG_ADDR[31:AW+2], bus.PROG_ADDR[1:0],
                     word_full[BLOCK_ADDR_WIDTH+BEAT_WIDTH-1:AW]};

   instruction_memory_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_WIDTH  (AW)
   ) u_array (
      .clk   (CLK),
      .we    (prog_en),
      .waddr (bus.PROG_ADDR[AW+1:2]),
      .wdata (bus.PROG_DATA),
      .raddr (word_full[AW-1:0]),
      .rdata (rd_word)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         beat     <= '0;
         wait_cnt <= '0;
         blk      <= '0;
         readdata <= '0;
      end else begin
         state    <= state_nxt;
         beat     <= beat_nxt;
         wait_cnt <= wait_nxt;
         blk      <= blk_nxt;
         if (load_beat) begin
            readdata[WORD_WIDTH*beat +: WORD_WIDTH] <= rd_word;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      wait_nxt  = wait_cnt;
      blk_nxt   = blk;
      case (state)
         IDLE: begin
            if (bus.READ) begin
               blk_nxt  = bus.ADDRESS;
               beat_nxt = '0;
               if (LATENCY > 0) begin
                  state_nxt = WAIT;
                  wait_nxt  = WAIT_INIT;
               end else begin
                  state_nxt = FETCH;
               end
            end
         end
         WAIT: begin
            if (!bus.READ) begin
               state_nxt = IDLE;
            end else if (wait_cnt == '0) begin
               state_nxt = FETCH;
               beat_nxt  = '0;
            end else begin
               wait_nxt = wait_cnt - 1'b1;
            end
         end
         FETCH: begin
            if (!bus.READ) begin
               state_nxt = IDLE;
            end else if (beat == BEAT_WIDTH'(BLOCK_WORDS - 1)) begin
               state_nxt = DONE;
            end else begin
               beat_nxt = beat + 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Combinational so the cache sees BUSYWAIT high in the very cycle it raises READ.
   assign bus.BUSYWAIT = !RESET && (((state == IDLE) && bus.READ) ||
                                    (state == WAIT) || (state == FETCH));
   assign bus.READDATA = readdata;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: a LATENCY=4 instance and a LATENCY=0 instance sharing the program port.
module tb_instruction_memory;
   import instruction_memory_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instruction_memory_if bus ();
   instruction_memory_if bus0 ();

   assign bus0.PROG_WRITE = bus.PROG_WRITE;
   assign bus0.PROG_ADDR  = bus.PROG_ADDR;
   assign bus0.PROG_DATA  = bus.PROG_DATA;

   instruction_memory #(.LATENCY(4), .DEPTH_WORDS(1024)) u_dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   instruction_memory #(.LATENCY(0), .DEPTH_WORDS(1024)) u_dut0 (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus0)
   );

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] B0 = {32'h16, 32'h15, 32'h14, 32'h13};
   localparam logic [127:0] B1 = {32'h1A, 32'h19, 32'h18, 32'h17};

   typedef struct {
      int           sel;
      logic [27:0]  addr;
      logic [127:0] exp_data;
      int           exp_low;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_read(input int sel, input logic r, input logic [27:0] a);
      if (sel == 0) begin
         bus.READ    = r;
         bus.ADDRESS = a;
      end else begin
         bus0.READ    = r;
         bus0.ADDRESS = a;
      end
   endtask

   function automatic logic busy(input int sel);
      return (sel == 0) ? bus.BUSYWAIT : bus0.BUSYWAIT;
   endfunction

   function automatic logic [127:0] rdata(input int sel);
      return (sel == 0) ? bus.READDATA : bus0.READDATA;
   endfunction

   task automatic prog(input logic [31:0] a, input logic [31:0] d);
      bus.PROG_WRITE = 1'b1;
      bus.PROG_ADDR  = a;
      bus.PROG_DATA  = d;
      next_cycle();
      bus.PROG_WRITE = 1'b0;
   endtask

   // Entered #1 after an edge; READ rises in cycle 0. Returns the first cycle with BUSYWAIT low
   // (-1 if none within the budget) and READDATA in that cycle. Ends #1 into the following cycle.
   task automatic do_read(input int sel, input logic [27:0] a, input bit drop,
                          output int lowc, output logic [127:0] data);
      lowc = -1;
      data = '0;
      set_read(sel, 1'b1, a);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy(sel)) begin
            lowc = c;
            data = rdata(sel);
            break;
         end
         next_cycle();
      end
      next_cycle();
      if (drop) set_read(sel, 1'b0, a);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int           lc;
      logic [127:0] d;

      vecs[0] = '{0, 28'h0000000, B0, 9};
      vecs[1] = '{0, 28'h0000001, B1, 9};
      vecs[2] = '{0, 28'h0000101, B1, 9};
      vecs[3] = '{0, 28'hFFFFF00, B0, 9};
      vecs[4] = '{1, 28'h0000100, B0, 5};
      vecs[5] = '{1, 28'h0000001, B1, 5};

      rst = 1'b1;
      bus.READ = 1'b0;  bus.ADDRESS = '0;
      bus0.READ = 1'b0; bus0.ADDRESS = '0;
      bus.PROG_WRITE = 1'b0; bus.PROG_ADDR = '0; bus.PROG_DATA = '0;
      next_cycle();
      bus.READ = 1'b1;
      @(negedge clk);
      check("rst_busywait_gated", 128'(bus.BUSYWAIT), 128'd0);
      check("rst_readdata", bus.READDATA, 128'd0);
      check("rst_state", 128'(u_dut.state), 128'(IDLE));
      next_cycle();
      bus.READ = 1'b0;
      rst = 1'b0;

      for (int k = 0; k < 8; k++) prog(32'(k * 4), 32'h13 + 32'(k));

      for (int i = 0; i < 6; i++) begin
         do_read(vecs[i].sel, vecs[i].addr, 1'b1, lc, d);
         check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         check($sformatf("vec%0d_low_cycle", i), 128'(lc), 128'(vecs[i].exp_low));
      end

      // Back-to-back with READ held: second DONE lands 10 cycles after the first.
      do_read(0, 28'h0, 1'b0, lc, d);
      check("b2b_first_data", d, B0);
      check("b2b_first_low", 128'(lc), 128'd9);
      do_read(0, 28'h1, 1'b1, lc, d);
      check("b2b_second_data", d, B1);
      check("b2b_second_low", 128'(lc), 128'd9);

      // Abort during the second FETCH beat (cycle 6).
      set_read(0, 1'b1, 28'h0);
      for (int c = 0; c < 6; c++) next_cycle();
      set_read(0, 1'b0, 28'h0);
      next_cycle();
      @(negedge clk);
      check("abort_state", 128'(u_dut.state), 128'(IDLE));
      check("abort_busywait", 128'(bus.BUSYWAIT), 128'd0);
      next_cycle();
      do_read(0, 28'h0, 1'b1, lc, d);
      check("abort_reread_data", d, B0);
      check("abort_reread_low", 128'(lc), 128'd9);

      // Reset pulsed in WAIT (cycle 2) while reading block 1.
      set_read(0, 1'b1, 28'h1);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("wait_rst_busywait", 128'(bus.BUSYWAIT), 128'd0);
      next_cycle();
      rst = 1'b0;
      set_read(0, 1'b0, 28'h1);
      @(negedge clk);
      check("post_rst_busywait", 128'(bus.BUSYWAIT), 128'd0);
      check("post_rst_readdata", bus.READDATA, 128'd0);
      check("post_rst_state", 128'(u_dut.state), 128'(IDLE));
      next_cycle();
      do_read(0, 28'h0, 1'b1, lc, d);
      check("post_rst_reread_data", d, B0);
      check("post_rst_reread_low", 128'(lc), 128'd9);

      // Program write held across FETCH and DONE of a block-1 read must be ignored.
      set_read(0, 1'b1, 28'h1);
      for (int c = 0; c < 5; c++) next_cycle();
      bus.PROG_WRITE = 1'b1;
      bus.PROG_ADDR  = 32'h10;
      bus.PROG_DATA  = 32'hDEADBEEF;
      for (int c = 0; c < 5; c++) next_cycle();
      bus.PROG_WRITE = 1'b0;
      set_read(0, 1'b0, 28'h1);
      @(negedge clk);
      check("busy_write_block", bus.READDATA, B1);
      next_cycle();
      do_read(0, 28'h1, 1'b1, lc, d);
      check("busy_write_ignored", d, B1);
      check("busy_write_low", 128'(lc), 128'd9);
      prog(32'h10, 32'hDEADBEEF);
      do_read(0, 28'h1, 1'b1, lc, d);
      check("idle_write_data", d, {32'h1A, 32'h19, 32'h18, 32'hDEADBEEF});
      check("idle_write_low", 128'(lc), 128'd9);

      // READ dropped after DONE: no retrigger.
      @(negedge clk);
      check("no_retrigger_busywait", 128'(bus.BUSYWAIT), 128'd0);
      next_cycle();
      @(negedge clk);
      check("no_retrigger_state", 128'(u_dut.state), 128'(IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
